// File: rtl/agex_muldiv_unit_if.sv
// agex_muldiv_unit_if: issue/result handshake between the AGEX stage and the iterative mul/div unit
interface agex_muldiv_unit_if #(
    parameter int XLEN      = 32,
    parameter int REGNOBITS = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [XLEN-1:0]      src1;
    logic [XLEN-1:0]      src2;
    logic [REGNOBITS-1:0] rd_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      result;
    logic [REGNOBITS-1:0] rd_out;
    logic                 busy;

    modport master (
        output flush, in_valid, op, src1, src2, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    modport slave (
        input  flush, in_valid, op, src1, src2, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface

// File: rtl/agex_muldiv_unit.sv
// agex_muldiv_unit: iterative radix-2 RV32M/RV64M multiply/divide unit with 1-cycle special cases
module agex_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int REGNOBITS = 5,
    parameter int CNTBITS   = $clog2(XLEN) + 1
) (
    input logic                clk,
    input logic                reset,
    agex_muldiv_unit_if.slave  io_bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               r_state, w_state_nx;
    logic [CNTBITS-1:0]   r_cnt;
    logic [2:0]           r_op;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [XLEN-1:0]      r_b;
    logic [2*XLEN-1:0]    r_acc;
    logic [XLEN-1:0]      r_result;
    logic [REGNOBITS-1:0] r_rd_out;

    logic                 w_accept, w_last;
    logic                 w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
    logic [XLEN-1:0]      w_a_abs, w_b_abs, w_special_res;
    logic [XLEN:0]        w_mul_sum, w_trial, w_diff;
    logic [2*XLEN-1:0]    w_mul_nx, w_div_nx, w_acc_nx, w_prod;
    logic [XLEN-1:0]      w_quot, w_rem, w_calc_res;

    assign w_accept  = io_bus.in_valid && r_state == IDLE && !io_bus.flush && !reset;
    assign w_last    = r_cnt == CNTBITS'(XLEN - 1);

    // src1 is signed for MULH/MULHSU/DIV/REM, src2 only for MULH/DIV/REM
    assign w_a_neg   = io_bus.src1[XLEN-1] & (io_bus.op[2] ? ~io_bus.op[0] : io_bus.op[0] ^ io_bus.op[1]);
    assign w_b_neg   = io_bus.src2[XLEN-1] & (io_bus.op[2] ? ~io_bus.op[0] : io_bus.op[1:0] == 2'b01);
    assign w_a_abs   = w_a_neg ? -io_bus.src1 : io_bus.src1;
    assign w_b_abs   = w_b_neg ? -io_bus.src2 : io_bus.src2;

    assign w_div0    = io_bus.op[2] && io_bus.src2 == '0;
    assign w_ovf     = io_bus.op[2] && !io_bus.op[0] && io_bus.src1 == {1'b1, {(XLEN-1){1'b0}}} && &io_bus.src2;
    assign w_special = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (io_bus.op[1] ? io_bus.src1 : {XLEN{1'b1}})
                                  : (io_bus.op[1] ? {XLEN{1'b0}} : io_bus.src1);

    // Multiply: add multiplicand into the high half when the low bit is set, then shift right
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b & {XLEN{r_acc[0]}}};
    assign w_mul_nx  = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: {remainder, quotient} shifts left; the top bit of the trial difference is the borrow
    assign w_trial   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff    = w_trial - {1'b0, r_b};
    assign w_div_nx  = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_acc_nx  = r_op[2] ? w_div_nx : w_mul_nx;
    assign w_prod    = r_neg_q ? -w_acc_nx : w_acc_nx;
    assign w_quot    = r_neg_q ? -w_acc_nx[XLEN-1:0] : w_acc_nx[XLEN-1:0];
    assign w_rem     = r_neg_r ? -w_acc_nx[2*XLEN-1:XLEN] : w_acc_nx[2*XLEN-1:XLEN];
    assign w_calc_res = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                                : (r_op[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

    always_comb begin
        w_state_nx = r_state;
        if (io_bus.flush)
            w_state_nx = IDLE;
        else if (w_accept)
            w_state_nx = w_special ? DONE : CALC;
        else if (r_state == CALC && w_last)
            w_state_nx = DONE;
        else if (r_state == DONE && io_bus.out_ready)
            w_state_nx = IDLE;
    end

    always_ff @(posedge clk)
        r_state <= reset ? IDLE : w_state_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_op     <= io_bus.op;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b      <= w_b_abs;
            r_acc    <= {{XLEN{1'b0}}, w_a_abs};
            r_rd_out <= io_bus.rd_in;
            if (w_special)
                r_result <= w_special_res;
        end else if (r_state == CALC && !io_bus.flush) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_acc_nx;
            if (w_last)
                r_result <= w_calc_res;
        end
    end

    assign io_bus.in_ready  = r_state == IDLE;
    assign io_bus.busy      = r_state != IDLE;
    assign io_bus.out_valid = r_state == DONE;
    assign io_bus.result    = r_result;
    assign io_bus.rd_out    = r_rd_out;
endmodule
